// File: rtl/apb_slave_regbank_if.sv
// APB bus bundle between the master and the register-bank completer.
// The clock and reset stay outside the bundle as plain ports.
interface apb_slave_regbank_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
);
    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [ADDR_WIDTH-1:0] paddr;
    logic [DATA_WIDTH-1:0] pwdata;
    logic [DATA_WIDTH-1:0] prdata;
    logic                  pready;
    logic                  pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_slave_regbank.sv
// APB completer with DEPTH storage registers, a WAIT register at 0xFF and programmable wait states.
// Define APB_SLV_PSLVERR_EN to report out-of-range accesses through pslverr.
module apb_slave_regbank #(
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 8,
    parameter int DEPTH       = 16,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  pclk,
    input  logic                  presetn,
    apb_slave_regbank_if.slave    apb
);

    typedef enum logic {IDLE, ACCESS} state_t;

    localparam logic [ADDR_WIDTH-1:0] WAIT_ADDR  = ADDR_WIDTH'(255);
    localparam logic [3:0]            WAIT_RESET = 4'(WAIT_CYCLES);
`ifdef APB_SLV_PSLVERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    state_t                state_reg,   state_next;
    logic [ADDR_WIDTH-1:0] addr_reg,    addr_next;
    logic                  write_reg,   write_next;
    logic [DATA_WIDTH-1:0] wdata_reg,   wdata_next;
    logic [3:0]            cnt_reg,     cnt_next;
    logic [3:0]            wait_reg,    wait_next;
    logic                  pready_reg,  pready_next;
    logic                  pslverr_reg, pslverr_next;

    logic [DATA_WIDTH-1:0] regs [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  setup;
    logic                  commit;
    logic                  start;
    logic [3:0]            wait_eff;

    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
        return (a < ADDR_WIDTH'(DEPTH)) || (a == WAIT_ADDR);
    endfunction

    assign setup  = apb.psel && !apb.penable;
    assign commit = (state_reg == ACCESS) && pready_reg;

    // A WAIT write committing on this edge already governs a transfer accepted on the same edge.
    assign wait_eff = (commit && write_reg && (addr_reg == WAIT_ADDR)) ? wdata_reg[3:0] : wait_reg;

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_reg   <= IDLE;
            addr_reg    <= '0;
            write_reg   <= 1'b0;
            wdata_reg   <= '0;
            cnt_reg     <= '0;
            wait_reg    <= WAIT_RESET;
            pready_reg  <= 1'b0;
            pslverr_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            addr_reg    <= addr_next;
            write_reg   <= write_next;
            wdata_reg   <= wdata_next;
            cnt_reg     <= cnt_next;
            wait_reg    <= wait_next;
            pready_reg  <= pready_next;
            pslverr_reg <= pslverr_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        addr_next    = addr_reg;
        write_next   = write_reg;
        wdata_next   = wdata_reg;
        cnt_next     = cnt_reg;
        wait_next    = wait_eff;
        pready_next  = 1'b0;
        pslverr_next = 1'b0;
        start        = 1'b0;

        case (state_reg)
            IDLE: begin
                start = setup;
            end
            ACCESS: begin
                if (pready_reg) begin
                    if (setup) begin
                        start = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end else if (!apb.psel) begin
                    state_next = IDLE;
                end else if (cnt_reg <= 4'd1) begin
                    cnt_next     = '0;
                    pready_next  = 1'b1;
                    pslverr_next = ERR_EN && !in_range(addr_reg);
                end else begin
                    cnt_next = 4'(cnt_reg - 4'd1);
                end
            end
        endcase

        if (start) begin
            state_next   = ACCESS;
            addr_next    = apb.paddr;
            write_next   = apb.pwrite;
            wdata_next   = apb.pwdata;
            cnt_next     = wait_eff;
            pready_next  = (wait_eff == 4'd0);
            pslverr_next = ERR_EN && (wait_eff == 4'd0) && !in_range(apb.paddr);
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_store
            always_ff @(posedge pclk or negedge presetn) begin
                if (!presetn) begin
                    regs[gi] <= '0;
                end else if (commit && write_reg && (addr_reg == ADDR_WIDTH'(gi))) begin
                    regs[gi] <= wdata_reg;
                end
            end
        end
    endgenerate

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (addr_reg == ADDR_WIDTH'(i)) begin
                rd_data = regs[i];
            end
        end
        if (addr_reg == WAIT_ADDR) begin
            rd_data = DATA_WIDTH'(wait_reg);
        end
    end

    // Storage only changes at a commit edge, so the mux is stable for the whole pready cycle.
    assign apb.prdata  = (commit && !write_reg) ? rd_data : '0;
    assign apb.pready  = pready_reg;
    assign apb.pslverr = pslverr_reg;

endmodule

// File: tb/tb_apb_slave_regbank.sv
// Directed bench for apb_slave_regbank: reset, wait states, back-to-back, out-of-range, abort, mid-access reset.
module tb_apb_slave_regbank;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

`ifdef APB_SLV_PSLVERR_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    logic [7:0] exp_mem [16];

    apb_slave_regbank_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) bus ();

    apb_slave_regbank #(
        .ADDR_WIDTH (8),
        .DATA_WIDTH (8),
        .DEPTH      (16),
        .WAIT_CYCLES(2)
    ) dut (
        .pclk   (clk),
        .presetn(rst_n),
        .apb    (bus)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic apb_xfer(input bit wr, input logic [7:0] addr, input logic [7:0] data,
                            output logic [7:0] rdata, output int rcyc, output logic err,
                            output bit quiet_ok);
        @(posedge clk); #1;
        bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = wr; bus.paddr = addr; bus.pwdata = data;
        @(posedge clk); #1;
        bus.penable = 1'b1;
        bus.pwdata  = ~data;
        rcyc = -1; rdata = '0; err = 1'b0; quiet_ok = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            if (bus.pready === 1'b1) begin
                rcyc  = k;
                rdata = bus.prdata;
                err   = bus.pslverr;
                break;
            end
            if (bus.prdata !== 8'h00 || bus.pslverr !== 1'b0) quiet_ok = 1'b0;
            @(posedge clk); #1;
        end
        $display("xfer %s addr=%02h wdata=%02h -> ready_cycle=%0d prdata=%02h pslverr=%0b",
                 wr ? "WR" : "RD", addr, data, rcyc, rdata, err);
    endtask

    task automatic idle_cycle();
        @(posedge clk); #1;
        bus.psel = 1'b0; bus.penable = 1'b0;
        check_val("pready_drops_after_xfer", {31'd0, bus.pready}, 32'd0);
    endtask

    task automatic do_write(input string tag, input logic [7:0] addr, input logic [7:0] data,
                            input int exp_cyc, input logic exp_err, input bit b2b);
        logic [7:0] rd; int cyc; logic err; bit q;
        apb_xfer(1'b1, addr, data, rd, cyc, err, q);
        check_val({tag, "_cyc"},   32'(cyc), 32'(exp_cyc));
        check_val({tag, "_err"},   {31'd0, err}, {31'd0, exp_err});
        check_val({tag, "_prdata"}, {24'd0, rd}, 32'd0);
        check_val({tag, "_quiet"}, {31'd0, q}, 32'd1);
        if (!b2b) idle_cycle();
    endtask

    task automatic do_read(input string tag, input logic [7:0] addr, input logic [7:0] exp_data,
                           input int exp_cyc, input logic exp_err);
        logic [7:0] rd; int cyc; logic err; bit q;
        apb_xfer(1'b0, addr, 8'h00, rd, cyc, err, q);
        check_val({tag, "_cyc"},   32'(cyc), 32'(exp_cyc));
        check_val({tag, "_err"},   {31'd0, err}, {31'd0, exp_err});
        check_val({tag, "_data"},  {24'd0, rd}, {24'd0, exp_data});
        check_val({tag, "_quiet"}, {31'd0, q}, 32'd1);
        idle_cycle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0; bus.paddr = '0; bus.pwdata = '0;
        for (int i = 0; i < 16; i++) exp_mem[i] = 8'h00;

        // Reset
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_prdata",  {24'd0, bus.prdata}, 32'd0);
        check_val("rst_pready",  {31'd0, bus.pready}, 32'd0);
        check_val("rst_pslverr", {31'd0, bus.pslverr}, 32'd0);
        rst_n = 1'b1;
        do_read("rd_03_reset", 8'h03, 8'h00, 3, 1'b0);
        do_read("rd_ff_reset", 8'hFF, 8'h02, 3, 1'b0);

        // Default wait states
        do_write("wr_05_aa", 8'h05, 8'hAA, 3, 1'b0, 1'b0);
        exp_mem[5] = 8'hAA;
        do_read("rd_05", 8'h05, 8'hAA, 3, 1'b0);

        // Zero wait, back-to-back
        do_write("wr_ff_00", 8'hFF, 8'h00, 3, 1'b0, 1'b1);
        do_write("wr_0f_55", 8'h0F, 8'h55, 1, 1'b0, 1'b0);
        exp_mem[15] = 8'h55;
        do_read("rd_0f", 8'h0F, 8'h55, 1, 1'b0);
        do_read("rd_ff_zero", 8'hFF, 8'h00, 1, 1'b0);

        // Out of range
        do_write("wr_10_oor", 8'h10, 8'h77, 1, EXP_ERR, 1'b0);
        do_read("rd_10_oor", 8'h10, 8'h00, 1, EXP_ERR);
        for (int i = 0; i < 16; i++) begin
            do_read($sformatf("rd_scan_%02h", i), 8'(i), exp_mem[i], 1, 1'b0);
        end

        // Abort with WAIT=2
        do_write("wr_ff_02", 8'hFF, 8'h02, 1, 1'b0, 1'b0);
        @(posedge clk); #1;
        bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b1; bus.paddr = 8'h02; bus.pwdata = 8'h33;
        @(posedge clk); #1;
        bus.penable = 1'b1;
        check_val("abort_acc1_pready", {31'd0, bus.pready}, 32'd0);
        @(posedge clk); #1;
        bus.psel = 1'b0; bus.penable = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check_val("abort_no_pready", {31'd0, bus.pready}, 32'd0);
            @(posedge clk); #1;
        end
        $display("xfer WR addr=02 wdata=33 -> aborted after 1 access cycle");
        do_read("rd_02_after_abort", 8'h02, 8'h00, 3, 1'b0);

        // Reset in the middle of a WAIT=5 write
        do_write("wr_ff_05", 8'hFF, 8'h05, 3, 1'b0, 1'b0);
        @(posedge clk); #1;
        bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b1; bus.paddr = 8'h01; bus.pwdata = 8'h44;
        @(posedge clk); #1;
        bus.penable = 1'b1;
        @(posedge clk); #1;
        check_val("midrst_wait_pready", {31'd0, bus.pready}, 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("midrst_pready",  {31'd0, bus.pready}, 32'd0);
        check_val("midrst_prdata",  {24'd0, bus.prdata}, 32'd0);
        check_val("midrst_pslverr", {31'd0, bus.pslverr}, 32'd0);
        bus.psel = 1'b0; bus.penable = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        $display("xfer WR addr=01 wdata=44 -> reset during wait states");
        do_read("rd_01_after_rst", 8'h01, 8'h00, 3, 1'b0);
        do_read("rd_ff_after_rst", 8'hFF, 8'h02, 3, 1'b0);
        do_read("rd_05_after_rst", 8'h05, 8'h00, 3, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
